// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and counter widths.
// Used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_W      = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam int   BAUD_CNT_W  = 16;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [DATA_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..BAUD_TICK-1 while enabled and pulses bit_done
// on the last count of each bit. Shared between transmitter and receiver.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int BAUD_TICK = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic bit_done
);

    localparam logic [BAUD_CNT_W-1:0] TERMINAL = BAUD_CNT_W'(BAUD_TICK - 1);

    logic [BAUD_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= (count == TERMINAL) ? '0 : count + 1'b1;
        end
    end

    assign bit_done = enable && !clear && (count == TERMINAL);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: single-entry holding register feeding a frame shifter.
// Even parity bit is present only when UART_TX_PARITY_EN is defined.
//
//  state  | meaning
//  IDLE   | line high, waiting for the holding register to fill
//  START  | start bit (low) for one bit period
//  DATA   | data bits, LSB first, one bit period each
//  PARITY | even parity bit (UART_TX_PARITY_EN builds only)
//  STOP   | stop bit (high); reloads straight into START if a byte is waiting
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int BAUD_RATE  = 9600,
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              write,
    output logic              tx,
    output logic              txrdy,
    output logic              txempty,
    output logic              werr
);

    localparam int BAUD_TICK = CLOCK_FREQ / BAUD_RATE;

    uart_state_e       state;
    uart_state_e       state_next;
    logic [3:0]        bit_cnt;
    logic [3:0]        bit_cnt_next;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] shifter;
    logic              hold_full;
    logic              accept;
    logic              load;
    logic              bit_done;
    logic              tx_next;

    uart_baud_counter #(
        .BAUD_TICK (BAUD_TICK)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == IDLE),
        .enable   (state != IDLE),
        .bit_done (bit_done)
    );

    assign accept = write && !hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            tx      <= STOP_LEVEL;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        case (state)
            IDLE: begin
                if (hold_full) state_next = START;
            end
            START: begin
                if (bit_done) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) state_next = STOP;
            end
`endif
            STOP: begin
                if (bit_done) state_next = hold_full ? START : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // tx is registered from the next state so each bit starts on the edge it is entered.
    always_comb begin
        load    = hold_full && ((state == IDLE) || ((state == STOP) && bit_done));
        tx_next = STOP_LEVEL;
        case (state_next)
            START:   tx_next = START_LEVEL;
            DATA:    tx_next = shifter[bit_cnt_next[2:0]];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = even_parity(shifter);
`endif
            default: tx_next = STOP_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            werr      <= 1'b0;
        end else begin
            if (accept) begin
                hold      <= data;
                hold_full <= 1'b1;
                werr      <= 1'b0;
            end else if (write) begin
                werr      <= 1'b1;
            end
            if (load) begin
                shifter   <= hold;
                hold_full <= 1'b0;
            end
        end
    end

    assign txrdy   = !hold_full;
    assign txempty = (state == IDLE) && !hold_full;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a line monitor decodes every frame on tx
// and compares it bit-by-bit against bytes queued by the stimulus process.
module tb_uart_transmitter;

    localparam int TICK  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * TICK;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_r;
    logic       write_r;
    logic       tx;
    logic       txrdy;
    logic       txempty;
    logic       werr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    bit         mon_busy = 1'b0;
    int         bit_idx;
    int         sub;
    bit         bit_bad;
    logic [7:0] cur_byte;
    logic       frame_bits[0:10];

    uart_transmitter #(
        .BAUD_RATE  (1),
        .CLOCK_FREQ (16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (data_r),
        .write   (write_r),
        .tx      (tx),
        .txrdy   (txrdy),
        .txempty (txempty),
        .werr    (werr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Expected line levels for one frame, built from the byte with plain arithmetic.
    task automatic build_frame(input logic [7:0] b);
        int ones;
        int v;
        ones = 0;
        v    = int'(b);
        frame_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            frame_bits[i+1] = ((v / (1 << i)) % 2) == 1;
            ones += (v / (1 << i)) % 2;
        end
        frame_bits[9]  = (NBITS == 11) ? ((ones % 2) == 1) : 1'b1;
        frame_bits[10] = 1'b1;
    endtask

    // Line monitor: one comparison per bit period, every sample inside it must match.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
            end else begin
                if (!mon_busy && tx === 1'b0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=start_bit required=idle at cycle %0d", cyc);
                    end else begin
                        cur_byte = exp_q.pop_front();
                        build_frame(cur_byte);
                        starts.push_back(cyc);
                        mon_busy = 1'b1;
                        bit_idx  = 0;
                        sub      = 0;
                        bit_bad  = 1'b0;
                    end
                end
                if (mon_busy) begin
                    if (tx !== frame_bits[bit_idx]) bit_bad = 1'b1;
                    sub++;
                    if (sub == TICK) begin
                        checks++;
                        if (bit_bad) begin
                            errors++;
                            $display("FAIL frame_bit byte=%0h bit=%0d actual=unstable_or_wrong required=%0b",
                                     cur_byte, bit_idx, frame_bits[bit_idx]);
                        end
                        sub     = 0;
                        bit_bad = 1'b0;
                        bit_idx++;
                        if (bit_idx == NBITS) mon_busy = 1'b0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; the write lands on the next edge.
    task automatic do_write(input logic [7:0] b, input bit accepted);
        data_r  = b;
        write_r = 1'b1;
        if (accepted) exp_q.push_back(b);
        @(posedge clk);
        #1;
        write_r = 1'b0;
    endtask

    task automatic wait_rdy();
        int n;
        n = 0;
        while (txrdy !== 1'b1 && n < 2 * FRAME + 10) begin
            step(1);
            n++;
        end
        if (txrdy !== 1'b1) check("wait_txrdy_timeout", txrdy, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(txempty === 1'b1 && !mon_busy) && n < 3 * FRAME) begin
            step(1);
            n++;
        end
        check("wait_idle", {txempty, mon_busy}, 2'b10);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dir_bytes[6];
        int gap;
        dir_bytes = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'h80, 8'h7E};

        rst_n   = 1'b0;
        write_r = 1'b0;
        data_r  = 8'h00;
        #12;
        check("reset_tx", tx, 1);
        check("reset_txrdy", txrdy, 1);
        check("reset_txempty", txempty, 1);
        check("reset_werr", werr, 0);
        #8 rst_n = 1'b1;
        step(2);

        // Single byte: start bit one edge after the write, txempty back after a full frame.
        do_write(8'hA5, 1'b1);
        check("single_txrdy_after_write", txrdy, 0);
        check("single_tx_still_idle", tx, 1);
        step(1);
        check("single_txrdy_after_load", txrdy, 1);
        check("single_tx_start", tx, 0);
        step(FRAME - 1);
        check("single_txempty_last_cycle", txempty, 0);
        step(1);
        check("single_txempty_done", txempty, 1);
        wait_idle();

        for (int i = 1; i < 6; i++) begin
            wait_rdy();
            do_write(dir_bytes[i], 1'b1);
            wait_idle();
        end

        // Back-to-back frames with a byte queued mid-frame.
        starts.delete();
        do_write(8'h55, 1'b1);
        step(19);
        check("b2b_txrdy_before", txrdy, 1);
        do_write(8'h3C, 1'b1);
        check("b2b_txrdy_held", txrdy, 0);
        step(FRAME - 20);
        check("b2b_txrdy_end_frame", txrdy, 0);
        step(1);
        check("b2b_txrdy_transfer", txrdy, 1);
        check("b2b_tx_start", tx, 0);
        wait_idle();
        check("b2b_frames", starts.size(), 2);
        if (starts.size() >= 2) check("b2b_gap", starts[1] - starts[0], FRAME);

        // Write while full.
        do_write(8'h11, 1'b1);
        step(1);
        do_write(8'h22, 1'b1);
        check("full_txrdy", txrdy, 0);
        check("full_werr_clear", werr, 0);
        do_write(8'h33, 1'b0);
        check("full_werr_set", werr, 1);
        wait_rdy();
        check("full_werr_sticky", werr, 1);
        do_write(8'h44, 1'b1);
        check("full_werr_cleared", werr, 0);
        wait_idle();

        // Reset during data bit 4 of 0x0F, with a second byte held and werr set.
        do_write(8'h0F, 1'b1);
        step(1);
        do_write(8'h5A, 1'b1);
        do_write(8'h66, 1'b0);
        check("rst_pre_werr", werr, 1);
        step(85);
        check("rst_pre_tx_bit4", tx, 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("rst_tx", tx, 1);
        check("rst_txrdy", txrdy, 1);
        check("rst_txempty", txempty, 1);
        check("rst_werr", werr, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(2);
        check("rst_line_quiet", tx, 1);
        do_write(8'hC3, 1'b1);
        wait_idle();

        // Randomized stream with random idle gaps, sometimes back-to-back.
        for (int i = 0; i < 24; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : int'($urandom_range(0, 20));
            if (gap > 0) step(gap);
            wait_rdy();
            do_write(8'($urandom), 1'b1);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
